// File: rtl/bus_pkg.sv
// Shared definitions for the unidirectional system bus: Control field layout,
// transfer-type encodings, size/burst codes and burst-length decode.
package bus_pkg;

  localparam int CTRL_W         = 9;
  localparam int CTRL_TRANS_LSB = 7;
  localparam int CTRL_WRITE_BIT = 6;
  localparam int CTRL_SIZE_LSB  = 4;
  localparam int CTRL_BURST_LSB = 1;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_NONSEQ = 2'b01,
    TR_SEQ    = 2'b10,
    TR_BUSY   = 2'b11
  } trans_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR4  = 3'b001;
  localparam logic [2:0] BU_INCR8  = 3'b010;
  localparam logic [2:0] BU_INCR16 = 3'b011;

  // Reserved burst codes behave as a single transfer.
  function automatic logic [2:0] burst_norm(input logic [2:0] burst);
    return (burst > BU_INCR16) ? BU_SINGLE : burst;
  endfunction

  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      BU_INCR4:  return 5'd4;
      BU_INCR8:  return 5'd8;
      BU_INCR16: return 5'd16;
      default:   return 5'd1;
    endcase
  endfunction

  function automatic logic [CTRL_W-1:0] make_control(input trans_t     trans,
                                                     input logic       write,
                                                     input logic [1:0] size,
                                                     input logic [2:0] burst);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_TRANS_LSB +: 2] = trans;
    c[CTRL_WRITE_BIT]      = write;
    c[CTRL_SIZE_LSB +: 2]  = size;
    c[CTRL_BURST_LSB +: 3] = burst;
    return c;
  endfunction

endpackage

// File: rtl/biu_addr_gen.sv
// Current bus address and remaining-beat counter for the master BIU.
// Increments by the transfer size with plain 32-bit rollover.
module biu_addr_gen
  import bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] start_addr,
  input  logic [2:0]  burst,
  input  logic [1:0]  size,
  output logic [31:0] addr,
  output logic        last
);

  logic [4:0]  remaining;
  logic [31:0] step;

  assign step = 32'd1 << size;
  assign last = (remaining == 5'd1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= start_addr;
      remaining <= burst_len(burst);
    end else if (advance && remaining != 5'd0) begin
      addr      <= addr + step;
      remaining <= remaining - 5'd1;
    end
  end

endmodule

// File: rtl/master_biu.sv
// Initiator-side bus interface unit: turns local single/burst requests into
// bus beats toward a slave BIU, with BUSY stalls and a per-beat timeout.
module master_biu
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [2:0]  req_burst,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] Address,
  output logic [8:0]  Control,
  output logic [31:0] DataOut,
  input  logic [31:0] DataIn,
  input  logic        Ready,
  output logic        en
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_BUSY, S_FIN} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        write_q;
  logic [1:0]  size_q;
  logic [2:0]  burst_q;
  logic        started_q;
  logic [7:0]  tcnt;
  logic [8:0]  control_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        last;
  logic        load;
  logic        beat_ok;

  assign load    = (state == S_IDLE) && req_valid;
  assign beat_ok = (state == S_BEAT) && Ready;

  biu_addr_gen u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .advance    (beat_ok),
    .start_addr (req_addr),
    .burst      (req_burst),
    .size       (size_q),
    .addr       (Address),
    .last       (last)
  );

  // Decoded straight from the state register so reset takes effect at once.
  assign req_ready   = (state == S_IDLE);
  assign en          = (state == S_BEAT) || (state == S_BUSY);
  assign wdata_ready = beat_ok && write_q;
  assign DataOut     = ((state == S_BEAT) && write_q) ? wdata : '0;
  assign Control     = control_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign done        = done_q;
  assign err         = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      write_q   <= 1'b0;
      size_q    <= '0;
      burst_q   <= '0;
      started_q <= 1'b0;
      tcnt      <= '0;
      control_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            burst_q   <= burst_norm(req_burst);
            started_q <= 1'b0;
            tcnt      <= '0;
            if (req_write && !wdata_valid) begin
              state     <= S_BUSY;
              control_q <= make_control(TR_BUSY, req_write, req_size, burst_norm(req_burst));
            end else begin
              state     <= S_BEAT;
              control_q <= make_control(TR_NONSEQ, req_write, req_size, burst_norm(req_burst));
            end
          end
        end

        S_BEAT: begin
          if (Ready) begin
            started_q <= 1'b1;
            tcnt      <= '0;
            if (!write_q) begin
              rdata_q  <= DataIn;
              rvalid_q <= 1'b1;
            end
            if (last) begin
              state     <= S_FIN;
              control_q <= '0;
              done_q    <= 1'b1;
            end else if (write_q && !wdata_valid) begin
              state     <= S_BUSY;
              control_q <= make_control(TR_BUSY, write_q, size_q, burst_q);
            end else begin
              control_q <= make_control(TR_SEQ, write_q, size_q, burst_q);
            end
          end else if (tcnt == TMO_LAST) begin
            // Slave stalled too long: drop the remaining beats and flag it.
            state     <= S_FIN;
            control_q <= '0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        S_BUSY: begin
          if (wdata_valid) begin
            state     <= S_BEAT;
            tcnt      <= '0;
            control_q <= make_control(started_q ? TR_SEQ : TR_NONSEQ,
                                      write_q, size_q, burst_q);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/master_biu.md
# master_biu

Initiator-side bus interface unit for the unidirectional system bus. It accepts single or incrementing-burst read/write requests from a local client (CPU or DMA), drives `Address`/`Control`/write data and `en` toward a slave BIU, and waits on the slave's `Ready`. It returns read data, per-beat write-data handshakes, and a completion/error pulse. It sits opposite the SDRAM slave BIU on the same bus.

## Interface
- `TIMEOUT`, 255: cycles a beat may wait for `Ready` before abort (1..255).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: local request present.
- `req_ready` out 1: request accepted this cycle when both high.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 32: start byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word.
- `req_burst` in 3: 000 single, 001 incr4, 010 incr8, 011 incr16; others treated as single.
- `wdata` in 32: write data for the current beat.
- `wdata_valid` in 1 / `wdata_ready` out 1: write-beat handshake.
- `rdata` out 32 / `rdata_valid` out 1: read beat result.
- `done` out 1 / `err` out 1: one-cycle completion pulse; `err`=1 on timeout.
- `Address` out 32: bus address.
- `Control` out 9: [8:7] trans (00 IDLE, 01 NONSEQ, 10 SEQ, 11 BUSY), [6] write, [5:4] size, [3:1] burst, [0] = 0.
- `DataOut` out 32: write data to slave `DataIn`.
- `DataIn` in 32: read data from slave `DataOut`.
- `Ready` in 1: slave beat-complete strobe.
- `en` out 1: slave enable, high for the whole transaction.

## Operation
- Reset values: `req_ready`=1; `en`=0; `Control`=0 (IDLE); `Address`, `DataOut` and `rdata` are 0; `rdata_valid`, `wdata_ready`, `done` and `err` are 0. All registers, including state, clear asynchronously.
- States: IDLE, BEAT, BUSY, FIN.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch the request, load the beat count (1/4/8/16), and go to BEAT.
  - For a write with `wdata_valid`=0, go to BUSY instead.
- BEAT:
  - Drive `en`=1, `Address`=current, trans = NONSEQ for the first beat and SEQ for later beats.
  - For writes, `DataOut`=`wdata`.
  - A beat completes on a cycle with `Ready`=1. On completion:
    - Write: `wdata_ready`=1 in the same cycle (combinational, gated by state).
    - Read: `rdata` is registered from `DataIn` and `rdata_valid` pulses on the next cycle.
    - Address advances by 1<<size, modulo 2^32, with no boundary wrap. Bursts crossing 1 KB are the client's responsibility.
  - After the last beat, go to FIN. Otherwise, for a write with `wdata_valid`=0, go to BUSY; otherwise stay in BEAT.
- BUSY:
  - Write only. `en`=1, trans=11, `Address` held, `Ready` ignored.
  - Return to BEAT once `wdata_valid`=1; that beat is still NONSEQ if no beat has completed yet.
- FIN: one cycle with `en`=0, IDLE, `done`=1, `err`=0; then go to IDLE.
- Timeout:
  - A counter clears on entry to each beat and counts BEAT cycles with `Ready`=0.
  - On reaching `TIMEOUT`, abort: next cycle `en`=0, `Control`=IDLE, `done`=1, `err`=1. Return to IDLE; remaining beats are dropped.
  - BUSY cycles do not count.
- `Ready` while in IDLE/FIN/BUSY is ignored.
- A new request is accepted only in IDLE, so there is no back-to-back overlap.

## Timing
- Request accept at cycle T → `en`, `Address`, `Control` valid from T+1.
- Zero-wait slave (`Ready` high every cycle): one beat per cycle.
  - Single read: `rdata_valid` at T+2, `done` at T+2.
  - incr4 read: beats T+1..T+4, `rdata_valid` T+2..T+5, `done` T+5.
- `rdata_valid` always lags its `Ready` by exactly 1 cycle. The final `rdata_valid` coincides with `done`.
- Reset asserted mid-burst: outputs return to reset values immediately (asynchronous). No `done` is issued.

## Structure
- Shared package `bus_pkg`:
  - Control field bit positions.
  - Trans encodings IDLE/NONSEQ/SEQ/BUSY.
  - Size and burst codes.
  - Burst-length decode function.
- Sub-module `biu_addr_gen`: holds the current address and remaining beat count; inputs load/advance/size; outputs address and last-beat flag.
- FSM and timeout counter live in `master_biu`.

## Test plan
- Single write, addr 0x100, word, data 0xDEADBEEF, slave `Ready` after 2 waits → `Control`=0x040+size bits, trans 01, held 3 cycles; `wdata_ready` in the `Ready` cycle; `done`=1, `err`=0 next cycle.
- incr4 word read from 0x200, zero-wait → Address 0x200/0x204/0x208/0x20C, trans 01,10,10,10; `rdata_valid` 4 consecutive cycles with slave data; `done` with the last.
- incr8 halfword write with `wdata_valid` low for 2 cycles after beat 3 → trans 11 for 2 cycles, Address held at start+6, then SEQ resumes; 8 `wdata_ready` pulses in total.
- Read, slave never asserts `Ready`, `TIMEOUT`=4 → after 4 wait cycles: `en`=0, `done`=1, `err`=1, no `rdata_valid`; next request accepted.
- Address wrap: incr4 word read at 0xFFFFFFF8 → 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- `reset` pulsed during beat 2 of incr16 → `en`/`Control`/`req_ready` return to 0/0/1 with no clock edge; a subsequent single read completes normally.
